picorv32_dma_master: RTL

//  Bus initiator for the picorv32 native memory interface (mem_valid/mem_ready). Copies LEN 32-bit words

---
 rtl/picorv32_dma_pkg.sv | 17 +
 rtl/picorv32_dma_master_buf.sv | 26 ++
 rtl/picorv32_dma_master.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/picorv32_dma_pkg.sv
// Shared types and constants for the picorv32 native-bus DMA copy engine.
package picorv32_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_RD,
    S_RGAP,
    S_WR,
    S_WGAP,
    S_FIN
  } dma_state_e;

  localparam logic [3:0] WSTRB_WORD = 4'hF;
  localparam logic [3:0] WSTRB_READ = 4'h0;

endpackage

// File: rtl/picorv32_dma_master_buf.sv
// BURST x 32 staging register file between the read and write phases of a chunk.
module dma_burst_buf #(
  parameter int BURST = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  logic [31:0]      i_wdata,
  input  logic [IDX_W-1:0] i_ridx,
  output logic [31:0]      o_rdata
);

  logic [BURST-1:0][31:0] r_mem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_mem <= '0;
    else if (i_clr) r_mem <= '0;
    else if (i_we)  r_mem[i_widx] <= i_wdata;
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/picorv32_dma_master.sv
// Word-copy DMA initiator on the picorv32 mem_valid/mem_ready port: reads a
// chunk of up to BURST words into a buffer, then writes it out, until LEN done.
module picorv32_dma_master
  import picorv32_dma_pkg::*;
#(
  parameter int BURST = 4,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             aborted,
  output logic [LEN_W-1:0] words_done,
  output logic             mem_valid,
  output logic             mem_instr,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_ready,
  input  logic [31:0]      mem_rdata
);

  localparam int CNT_W  = $clog2(BURST) + 1;
  localparam int BIDX_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [LEN_W-1:0] BURST_L = LEN_W'(BURST);

  dma_state_e       r_state, w_next;
  logic [31:0]      r_src, r_dst;
  logic [LEN_W-1:0] r_len, r_rem, r_words;
  logic [CNT_W-1:0] r_chunk, r_idx;
  logic             r_err, r_aborted;

  logic [LEN_W-1:0] w_min_in, w_min;
  logic             w_misal, w_chunk_end, w_accept;
  logic [31:0]      w_buf_rdata;

  assign w_misal     = (r_src[1:0] != 2'b00) || (r_dst[1:0] != 2'b00);
  assign w_chunk_end = (r_idx == r_chunk);
  assign w_accept    = (r_state == S_IDLE) && start;
  // Next chunk size: min(BURST, words not yet assigned to a chunk).
  assign w_min_in    = (r_state == S_CHECK) ? r_len : r_rem;
  assign w_min       = (w_min_in >= BURST_L) ? BURST_L : w_min_in;

  dma_burst_buf #(.BURST(BURST), .IDX_W(BIDX_W)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_accept),
    .i_we    ((r_state == S_RD) && mem_ready),
    .i_widx  (r_idx[BIDX_W-1:0]),
    .i_wdata (mem_rdata),
    .i_ridx  (r_idx[BIDX_W-1:0]),
    .o_rdata (w_buf_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = WSTRB_READ;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_CHECK;
      S_CHECK: begin
        if (w_misal || abort || (r_len == '0)) w_next = S_FIN;
        else                                   w_next = S_RD;
      end
      S_RD: begin
        mem_valid = 1'b1;
        mem_addr  = r_src;
        // abort only matters once the request has been accepted
        if (mem_ready) w_next = abort ? S_FIN : S_RGAP;
      end
      S_RGAP: begin
        if (abort)            w_next = S_FIN;
        else if (w_chunk_end) w_next = S_WR;
        else                  w_next = S_RD;
      end
      S_WR: begin
        mem_valid = 1'b1;
        mem_addr  = r_dst;
        mem_wdata = w_buf_rdata;
        mem_wstrb = WSTRB_WORD;
        if (mem_ready) w_next = abort ? S_FIN : S_WGAP;
      end
      S_WGAP: begin
        if (abort)            w_next = S_FIN;
        else if (w_chunk_end) w_next = (r_rem == '0) ? S_FIN : S_RD;
        else                  w_next = S_WR;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_src     <= '0;
      r_dst     <= '0;
      r_len     <= '0;
      r_rem     <= '0;
      r_words   <= '0;
      r_chunk   <= '0;
      r_idx     <= '0;
      r_err     <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (start) begin
          r_src     <= src_addr;
          r_dst     <= dst_addr;
          r_len     <= len;
          r_words   <= '0;
          r_err     <= 1'b0;
          r_aborted <= 1'b0;
        end
        S_CHECK: begin
          if (w_misal)    r_err     <= 1'b1;
          else if (abort) r_aborted <= 1'b1;
          r_chunk <= CNT_W'(w_min);
          r_rem   <= r_len - w_min;
          r_idx   <= '0;
        end
        S_RD: if (mem_ready) begin
          r_src <= r_src + 32'd4;
          r_idx <= r_idx + CNT_W'(1);
          if (abort) r_aborted <= 1'b1;
        end
        S_RGAP: begin
          if (abort)            r_aborted <= 1'b1;
          else if (w_chunk_end) r_idx     <= '0;
        end
        S_WR: if (mem_ready) begin
          r_dst   <= r_dst + 32'd4;
          r_idx   <= r_idx + CNT_W'(1);
          r_words <= r_words + LEN_W'(1);
          if (abort) r_aborted <= 1'b1;
        end
        S_WGAP: begin
          if (abort) r_aborted <= 1'b1;
          else if (w_chunk_end && (r_rem != '0)) begin
            r_chunk <= CNT_W'(w_min);
            r_rem   <= r_rem - w_min;
            r_idx   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE) && (r_state != S_FIN);
  assign done       = (r_state == S_FIN);
  assign err        = r_err;
  assign aborted    = r_aborted;
  assign words_done = r_words;
  assign mem_instr  = 1'b0;

endmodule
